// File: rtl/monster_slot_manager.sv
// Monster slot manager: buffers summon requests, allocates free slots,
// round-robin picks an occurring monster and counts goal arrivals.
module monster_slot_manager #(
  parameter int NUM_SLOTS = 16,
  parameter int TYPE_W    = 3,
  parameter int COORD_W   = 32,
  parameter int QDEPTH    = 4,
  parameter int CNT_W     = $clog2(NUM_SLOTS+1)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         summon_valid,
  input  logic [TYPE_W-1:0]            summon_type,
  output logic                         summon_ready,
  input  logic [NUM_SLOTS-1:0]         used_array,
  input  logic [NUM_SLOTS*COORD_W-1:0] offx_array,
  input  logic [NUM_SLOTS*COORD_W-1:0] offy_array,
  input  logic [NUM_SLOTS*TYPE_W-1:0]  occur_array,
  input  logic [NUM_SLOTS-1:0]         achieve_array,
  output logic [NUM_SLOTS-1:0]         enable_array,
  output logic [NUM_SLOTS*TYPE_W-1:0]  summon_array,
  output logic [TYPE_W-1:0]            monster_occur,
  output logic [COORD_W-1:0]           offset_x,
  output logic [COORD_W-1:0]           offset_y,
  output logic [$clog2(NUM_SLOTS)-1:0] occur_slot,
  output logic [CNT_W-1:0]             achieve_monsters,
  output logic [$clog2(QDEPTH+1)-1:0]  queue_count
);

  localparam int SW  = $clog2(NUM_SLOTS);
  localparam int QW  = $clog2(QDEPTH);
  localparam int QCW = $clog2(QDEPTH+1);

  logic [TYPE_W-1:0]    r_mem [QDEPTH];
  logic [QW-1:0]        r_wp;
  logic [QW-1:0]        r_rp;
  logic [QCW-1:0]       r_cnt;
  logic [NUM_SLOTS-1:0] r_resv;
  logic [SW-1:0]        r_rr;

  logic                        w_push;
  logic                        w_pop;
  logic [NUM_SLOTS-1:0]        w_free;
  logic [SW-1:0]               w_alloc;
  logic [NUM_SLOTS-1:0]        w_oh;
  logic [NUM_SLOTS*TYPE_W-1:0] w_summon;
  logic [TYPE_W-1:0]           w_occ [NUM_SLOTS];
  logic                        w_found;
  logic [SW-1:0]               w_sel;
  logic [SW-1:0]               w_idx;
  logic [CNT_W-1:0]            w_ach;

  assign summon_ready = (r_cnt != QCW'(QDEPTH));
  assign queue_count  = r_cnt;
  assign w_push = summon_valid && summon_ready && (summon_type != '0);
  assign w_free = ~used_array & ~r_resv;
  assign w_pop  = (r_cnt != '0) && (|w_free);

  always_comb begin
    w_alloc = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (w_free[i]) w_alloc = SW'(i);
    w_oh = '0;
    w_oh[w_alloc] = 1'b1;
    w_summon = '0;
    w_summon[int'(w_alloc)*TYPE_W +: TYPE_W] = r_mem[r_rp];
  end

  // Scan downward so the entry closest to r_rr wins last.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++)
      w_occ[i] = occur_array[i*TYPE_W +: TYPE_W];
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = NUM_SLOTS-1; k >= 0; k--) begin
      w_idx = SW'((int'(r_rr) + k) % NUM_SLOTS);
      if (w_occ[w_idx] != '0) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_ach = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_ach = w_ach + CNT_W'(achieve_array[i]);
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wp] <= summon_type;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wp             <= '0;
      r_rp             <= '0;
      r_cnt            <= '0;
      r_resv           <= '0;
      r_rr             <= '0;
      enable_array     <= '0;
      summon_array     <= '0;
      monster_occur    <= '0;
      offset_x         <= '0;
      offset_y         <= '0;
      occur_slot       <= '0;
      achieve_monsters <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + QCW'(w_push) - QCW'(w_pop);
      r_resv <= (r_resv & ~used_array) | (w_pop ? w_oh : '0);
      enable_array <= w_pop ? w_oh : '0;
      summon_array <= w_pop ? w_summon : '0;
      if (w_found) begin
        monster_occur <= w_occ[w_sel];
        offset_x      <= offx_array[int'(w_sel)*COORD_W +: COORD_W];
        offset_y      <= offy_array[int'(w_sel)*COORD_W +: COORD_W];
        occur_slot    <= w_sel;
        r_rr          <= SW'((int'(w_sel) + 1) % NUM_SLOTS);
      end else begin
        monster_occur <= '0;
      end
      achieve_monsters <= w_ach;
    end
  end

endmodule

// File: doc/monster_slot_manager.md
Name: monster_slot_manager

Overview:
- Parametrised successor of the monster slot allocator. It buffers summon requests in a small FIFO with a valid/ready handshake.
- It allocates queued requests one per cycle to the lowest-index free monster slot, reserving that slot until the slot reports itself used.
- It round-robin scans the slots to pick one occurring monster per cycle for the renderer, and reports a registered count of monsters that reached the goal.

Parameters:
- NUM_SLOTS, 16, number of monster slots (2..64).
- TYPE_W, 3, monster type width; type 0 means none.
- COORD_W, 32, signed x/y offset width.
- QDEPTH, 4, summon FIFO depth (power of 2, >=2).
- CNT_W, $clog2(NUM_SLOTS+1), width of the achieve count.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- summon_valid  in  1  summon request present.
- summon_type  in  TYPE_W  requested type; 0 is ignored.
- summon_ready  out  1  FIFO can accept (not full).
- used_array  in  NUM_SLOTS  slot i holds a live monster.
- offx_array  in  NUM_SLOTS*COORD_W  flattened x offsets; slot i at [i*COORD_W +: COORD_W].
- offy_array  in  NUM_SLOTS*COORD_W  flattened y offsets; same packing.
- occur_array  in  NUM_SLOTS*TYPE_W  per-slot type to draw; 0 means not visible.
- achieve_array  in  NUM_SLOTS  slot i has reached the goal.
- enable_array  out  NUM_SLOTS  one-hot, one-cycle spawn pulse.
- summon_array  out  NUM_SLOTS*TYPE_W  spawn type; nonzero only in the pulsed slot during its pulse.
- monster_occur  out  TYPE_W  selected occurring type; 0 if none.
- offset_x  out  COORD_W  selected slot x offset.
- offset_y  out  COORD_W  selected slot y offset.
- occur_slot  out  $clog2(NUM_SLOTS)  index of the selected slot.
- achieve_monsters  out  CNT_W  popcount of achieve_array.
- queue_count  out  $clog2(QDEPTH+1)  number of FIFO entries.

Behaviour:

Reset (Reset==0 at a rising edge):
- FIFO empties; queue_count=0.
- reserved mask=0; rr_ptr=0.
- enable_array=0; summon_array=0.
- monster_occur=0; offset_x=0; offset_y=0; occur_slot=0.
- achieve_monsters=0.
- Reset mid-allocation drops all queued requests and reservations; no enable pulse is produced in the following cycle.

FIFO:
- summon_ready = (queue_count != QDEPTH), derived from registered state only.
- Push on an edge when summon_valid && summon_ready && summon_type!=0.
- A summon_type of 0 is never pushed and does not count as a handshake.
- Pop condition: the FIFO is non-empty and free = ~used_array & ~reserved is nonzero.
- Push and pop on the same edge leave queue_count unchanged, and the order is preserved.
- There is no bypass. A request accepted at edge k can allocate at edge k+1 at the earliest, with enable high during the cycle after edge k+1.

Allocation (at most one per edge):
- On pop, i = lowest set bit of free.
- Register enable_array = one-hot(i) and summon_array slot i = head type; all other slots 0. Set reserved[i]=1.
- With no pop, enable_array=0 and summon_array=0. Pulses are exactly one cycle wide.
- reserved[i] clears on any edge where used_array[i]==1.
- A reserved slot is never reallocated, even though used_array[i] is still 0.
- If all slots are used or reserved, the head waits and later entries also wait (no reordering).

Occurrence scan (registered, 1-cycle latency):
- Search slots rr_ptr, rr_ptr+1, ... modulo NUM_SLOTS for the first j with occur_array[j]!=0.
- If found: monster_occur=occur[j], offset_x=offx[j], offset_y=offy[j], occur_slot=j, and rr_ptr=(j+1) mod NUM_SLOTS. This wraps from NUM_SLOTS-1 to 0.
- If none is found: monster_occur=0; offset_x, offset_y, occur_slot and rr_ptr hold their values.

Achieve count:
- achieve_monsters = popcount(achieve_array), registered (1-cycle latency).
- The result is exact up to NUM_SLOTS with no saturation needed.

All outputs are registered. No combinational input-to-output path exists except summon_ready, which depends on state only.

Test Plan:
- Reset low for 2 edges with all inputs active -> all outputs 0, summon_ready=1, queue_count=0.
- used_array=0, push type 3 at edge 1 -> enable_array=16'h0001 and slot 0 type=3 for one cycle after edge 2. Push type 5 while used_array still 0 -> goes to slot 1 (slot 0 is reserved).
- Push 5 requests back to back with used_array=16'hFFFF -> the first 4 are accepted, summon_ready=0, queue_count=4. Release slot 7 -> one pulse on bit 7, queue_count=3, summon_ready=1.
- occur nonzero on slots 2, 9, 15 -> monster_occur/occur_slot cycle 2, 9, 15, 2, ... with matching offsets. With all occur=0 -> monster_occur=0 and offsets hold.
- achieve_array=16'hF00F -> achieve_monsters=8 one cycle later. Set it to 0 -> 0 one cycle later.
- Push accepted at edge k, Reset low at edge k+1 -> no enable pulse; queue_count=0 after reset.
